// File: rtl/sound_player.sv
// sound_player: plays a short fixed melody per sound ID as a square wave on o_speaker.
// Build macro SOUND_PRIORITY_EN: while busy, accept a retrigger only if its ID >= the playing ID.
module sound_player #(
  parameter int CLK_HZ      = 12_000_000,
  parameter int NOTE_CYCLES = 1_200_000,
  parameter int GAP_CYCLES  = 120_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_soundselector,
  input  logic       i_playsound,
  output logic       o_speaker,
  output logic       o_busy
);

  localparam int HP_C5 = CLK_HZ / (2 * 523);
  localparam int HP_E5 = CLK_HZ / (2 * 659);
  localparam int HP_G5 = CLK_HZ / (2 * 784);
  localparam int HP_C6 = CLK_HZ / (2 * 1047);
  localparam int HP_G3 = CLK_HZ / (2 * 196);
  localparam int HP_D3 = CLK_HZ / (2 * 147);

  // Lowest note has the longest half-period and sizes the phase counter.
  localparam int PW = (HP_D3 > 1) ? $clog2(HP_D3) : 1;
  localparam int NW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] SND_UI    = 2'd0;
  localparam logic [1:0] SND_NEXT  = 2'd1;
  localparam logic [1:0] SND_CRASH = 2'd2;
  localparam logic [1:0] SND_CELEB = 2'd3;

  // state  | meaning
  // S_IDLE | silent, waiting for a trigger
  // S_TONE | square wave for the current note
  // S_GAP  | silent spacing between two notes of one sound
  typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;

  state_t          r_state;
  logic            r_play_q;
  logic [1:0]      r_sel;
  logic [1:0]      r_idx;
  logic [PW-1:0]   r_phase;
  logic [NW-1:0]   r_note;
  logic [GW-1:0]   r_gap;
  logic            r_speaker;

  state_t          w_state_nxt;
  logic [1:0]      w_sel_nxt;
  logic [1:0]      w_idx_nxt;
  logic [PW-1:0]   w_phase_nxt;
  logic [NW-1:0]   w_note_nxt;
  logic [GW-1:0]   w_gap_nxt;
  logic            w_speaker_nxt;
  logic            w_trig;
  logic            w_accept;
  logic [PW-1:0]   w_hp_last;
  logic [1:0]      w_idx_last;

  function automatic logic [PW-1:0] hp_last(input logic [1:0] sel, input logic [1:0] idx);
    int hp;
    hp = HP_C6;
    case (sel)
      SND_NEXT:  hp = (idx == 2'd0) ? HP_C5 : (idx == 2'd1) ? HP_E5 : HP_G5;
      SND_CRASH: hp = (idx == 2'd0) ? HP_G3 : HP_D3;
      SND_CELEB: begin
        case (idx)
          2'd0:    hp = HP_C5;
          2'd1:    hp = HP_E5;
          2'd2:    hp = HP_G5;
          default: hp = HP_C6;
        endcase
      end
      default:   hp = HP_C6;
    endcase
    return PW'(hp - 1);
  endfunction

  function automatic logic [1:0] idx_last(input logic [1:0] sel);
    case (sel)
      SND_UI:    return 2'd0;
      SND_NEXT:  return 2'd2;
      SND_CRASH: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

  assign w_trig     = i_playsound & ~r_play_q;
  assign w_hp_last  = hp_last(r_sel, r_idx);
  assign w_idx_last = idx_last(r_sel);

`ifdef SOUND_PRIORITY_EN
  assign w_accept = w_trig & ((r_state == S_IDLE) | (i_soundselector >= r_sel));
`else
  assign w_accept = w_trig;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_play_q  <= 1'b0;
      r_sel     <= '0;
      r_idx     <= '0;
      r_phase   <= '0;
      r_note    <= '0;
      r_gap     <= '0;
      r_speaker <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_play_q  <= i_playsound;
      r_sel     <= w_sel_nxt;
      r_idx     <= w_idx_nxt;
      r_phase   <= w_phase_nxt;
      r_note    <= w_note_nxt;
      r_gap     <= w_gap_nxt;
      r_speaker <= w_speaker_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_idx_nxt     = r_idx;
    w_phase_nxt   = r_phase;
    w_note_nxt    = r_note;
    w_gap_nxt     = r_gap;
    w_speaker_nxt = r_speaker;

    // An accepted trigger overrides whatever is playing, including the final note's last cycle.
    if (w_accept) begin
      w_state_nxt   = S_TONE;
      w_sel_nxt     = i_soundselector;
      w_idx_nxt     = '0;
      w_phase_nxt   = '0;
      w_note_nxt    = '0;
      w_gap_nxt     = '0;
      w_speaker_nxt = 1'b0;
    end else begin
      case (r_state)
        S_TONE: begin
          if (r_note == NOTE_LAST) begin
            w_state_nxt   = (r_idx == w_idx_last) ? S_IDLE : S_GAP;
            w_phase_nxt   = '0;
            w_note_nxt    = '0;
            w_gap_nxt     = '0;
            w_speaker_nxt = 1'b0;
          end else begin
            w_note_nxt = r_note + 1'b1;
            if (r_phase == w_hp_last) begin
              w_phase_nxt   = '0;
              w_speaker_nxt = ~r_speaker;
            end else begin
              w_phase_nxt = r_phase + 1'b1;
            end
          end
        end
        S_GAP: begin
          w_speaker_nxt = 1'b0;
          if (r_gap == GAP_LAST) begin
            w_state_nxt = S_TONE;
            w_idx_nxt   = r_idx + 2'd1;
            w_gap_nxt   = '0;
            w_phase_nxt = '0;
            w_note_nxt  = '0;
          end else begin
            w_gap_nxt = r_gap + 1'b1;
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_phase_nxt   = '0;
          w_note_nxt    = '0;
          w_gap_nxt     = '0;
          w_speaker_nxt = 1'b0;
        end
      endcase
    end
  end

  assign o_speaker = r_speaker;
  assign o_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_sound_player.sv
// Scoreboard bench for sound_player: each busy episode is summarised (length, rises,
// sum of rise offsets, high samples) and compared against hand-computed expectations.
module tb_sound_player;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] soundselector;
  logic       playsound;
  logic       speaker;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int id;
    int len;
    int rises;
    int sum;
    int hi;
  } exp_t;

  exp_t exp_q[$];

  int ep_len   = 0;
  int ep_rises = 0;
  int ep_sum   = 0;
  int ep_hi    = 0;
  bit in_ep    = 1'b0;
  bit prev_spk = 1'b0;
  int idle_hi  = 0;

  sound_player #(
    .CLK_HZ(100_000),
    .NOTE_CYCLES(200),
    .GAP_CYCLES(20)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_soundselector(soundselector),
    .i_playsound(playsound),
    .o_speaker(speaker),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int len, input int rises, input int sum, input int hi);
    exp_t e;
    e.id = id; e.len = len; e.rises = rises; e.sum = sum; e.hi = hi;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [1:0] id);
    @(negedge clk);
    soundselector = id;
    playsound     = 1'b1;
    @(negedge clk);
    playsound     = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      fails++;
      $display("FAIL %s timeout: busy still %0d after %0d cycles, expected 0", name, busy, budget);
    end
    repeat (5) @(negedge clk);
  endtask

  // Monitor: one record per contiguous busy episode, popped when busy drops.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      if (!in_ep) begin
        in_ep = 1'b1; ep_len = 0; ep_rises = 0; ep_sum = 0; ep_hi = 0;
      end
      if (speaker && !prev_spk) begin
        ep_rises++;
        ep_sum += ep_len;
      end
      if (speaker) ep_hi++;
      ep_len++;
    end else begin
      if (speaker) idle_hi++;
      if (in_ep) begin
        in_ep = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected episode: len %0d, expected no episode", ep_len);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("ep%0d len", e.id), ep_len, e.len);
          check($sformatf("ep%0d rises", e.id), ep_rises, e.rises);
          check($sformatf("ep%0d rise_sum", e.id), ep_sum, e.sum);
          check($sformatf("ep%0d high_samples", e.id), ep_hi, e.hi);
        end
      end
    end
    prev_spk = speaker;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    playsound     = 1'b0;
    soundselector = 2'd0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset speaker", speaker, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // UI_PRESS: rises at 47,141
    push(1, 200, 2, 188, 94);
    pulse(2'd0);
    wait_idle("t1", 2000);

    // NEXTLEVEL: rises 95, 295, 503, 629
    push(2, 640, 4, 1522, 244);
    pulse(2'd1);
    wait_idle("t2", 2000);

    // CELEBRATION with playsound held: single playback
    push(3, 860, 6, 3030, 338);
    @(negedge clk);
    soundselector = 2'd3;
    playsound     = 1'b1;
    repeat (1000) @(negedge clk);
    playsound     = 1'b0;
    wait_idle("t3", 2000);

    // NEXTLEVEL, then UI_PRESS trigger sampled 300 cycles later
`ifdef SOUND_PRIORITY_EN
    push(4, 640, 4, 1522, 244);
`else
    push(4, 500, 4, 1178, 194);
`endif
    pulse(2'd1);
    repeat (299) @(negedge clk);
    soundselector = 2'd0;
    playsound     = 1'b1;
    @(negedge clk);
    playsound     = 1'b0;
    wait_idle("t4", 2000);

    // CRASH aborted by reset 150 cycles in, with playsound raised alongside reset
    push(5, 150, 0, 0, 0);
    pulse(2'd2);
    repeat (149) @(negedge clk);
    reset     = 1'b1;
    playsound = 1'b1;
    @(negedge clk);
    check("t5 reset busy", busy, 0);
    check("t5 reset speaker", speaker, 0);
    repeat (2) @(negedge clk);
    push(6, 420, 0, 0, 0);
    reset = 1'b0;
    repeat (500) @(negedge clk);
    playsound = 1'b0;
    wait_idle("t5", 2000);

    // CRASH triggered on the last cycle of UI_PRESS: no idle gap in between
    push(7, 620, 2, 188, 94);
    pulse(2'd0);
    repeat (199) @(negedge clk);
    soundselector = 2'd2;
    playsound     = 1'b1;
    @(negedge clk);
    playsound     = 1'b0;
    wait_idle("t6", 2000);

    check("pending episodes", exp_q.size(), 0);
    check("speaker high while idle", idle_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sound_player.md
# sound_player

Tone sequencer downstream of the game-state controller. It consumes that block's `soundselector`/`playsound` pair and plays a short fixed melody for each sound type as a square wave on a single speaker pin. It sits between the game-state FSM and the board's piezo/speaker output and is the only block that drives audio.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency in Hz; used to derive tone half-periods.
- `NOTE_CYCLES`, 1_200_000, length of each note in clock cycles (100 ms at default clock).
- `GAP_CYCLES`, 120_000, silent gap between consecutive notes of one sound, in cycles.

- `clk`  input  1  system clock; all logic on posedge.
- `reset`  input  1  synchronous, active-high reset.
- `soundselector`  input  2  sound ID: 0 UI_PRESS, 1 NEXTLEVEL, 2 CRASH, 3 CELEBRATION.
- `playsound`  input  1  request; a 0→1 transition triggers playback of `soundselector`.
- `speaker`  output  1  square-wave audio output.
- `busy`  output  1  high while a sound is in progress (TONE or GAP).

## Operation
- Melody ROM (frequencies in Hz, played in order):
  - UI_PRESS: 1047.
  - NEXTLEVEL: 523, 659, 784.
  - CRASH: 196, 147.
  - CELEBRATION: 523, 659, 784, 1047.
- Half-period per note: HP = CLK_HZ / (2·f), integer division, computed at elaboration.
- Trigger: `playsound` is registered every cycle into `play_q`. Trigger = `playsound & ~play_q`. A level held high does not retrigger.
- On trigger, `soundselector` is latched, note index = 0, and the FSM enters TONE.
- FSM states:
  - IDLE: `speaker`=0, `busy`=0. Trigger → TONE.
  - TONE: the phase counter counts 0..HP-1. On reaching HP-1 it wraps to 0 and `speaker` toggles. The note counter counts 0..NOTE_CYCLES-1. At its terminal count: last note → IDLE; otherwise → GAP.
  - GAP: `speaker`=0 and counts GAP_CYCLES. At its terminal count: note index +1 → TONE.
- Each TONE entry clears the phase counter, and `speaker` starts at 0.
- Retrigger while busy (default build): the current sound aborts and the new sound starts at note 0, with the same timing as a trigger from IDLE.
- Counter widths: $clog2 of the respective maximum. No counter ever exceeds its terminal value.
- Reset outputs: `speaker`=0, `busy`=0, state IDLE, `play_q`=0, all counters 0.
- Reset mid-sound aborts immediately. A reset on the same cycle as a trigger: reset wins.
- `playsound` still high when reset deasserts: triggers once, because `play_q` resets to 0.

## Timing
- Trigger sampled at edge n: `busy`=1 and state TONE after edge n.
- The first `speaker` rise occurs HP cycles after edge n.
- Busy duration is exactly N·NOTE_CYCLES + (N-1)·GAP_CYCLES cycles, where N is the note count. `busy` falls on the edge ending the last note.
- There is no trailing gap after the last note.
- A trigger on the same cycle as the final note's terminal count starts the new sound: TONE, index 0, not IDLE.
- `speaker` is registered with no combinational path from the inputs.

## Configuration
- `SOUND_PRIORITY_EN` defined: a trigger while busy is accepted only if the new ID ≥ the latched ID. Otherwise the trigger is ignored and the current sound continues undisturbed. Triggers from IDLE are always accepted.
- `SOUND_PRIORITY_EN` undefined: every trigger restarts playback, as described in Operation.

## Test plan
Bench parameters: CLK_HZ=100_000, NOTE_CYCLES=200, GAP_CYCLES=20. HPs: 1047→47, 523→95, 659→75, 784→63, 196→255, 147→340.

- Reset, then pulse `playsound` with ID 0 → `busy` high for exactly 200 cycles. `speaker` toggles every 47 cycles, first rise 47 cycles after trigger. Then `busy`=0 and `speaker`=0.
- ID 1 trigger → 640 busy cycles. Toggle periods 95/75/63 in the three note windows. `speaker`=0 for the 20-cycle gaps at offsets 200–219 and 420–439.
- Hold `playsound` high for 1000 cycles with ID 3 → exactly one playback of 860 cycles, no retrigger.
- Start ID 1, then trigger ID 0 at cycle 300:
  - Default build: UI_PRESS plays, `busy` ends 200 cycles after the retrigger.
  - With `SOUND_PRIORITY_EN`: the trigger is ignored and NEXTLEVEL completes at 640.
- Assert `reset` 150 cycles into a CRASH (ID 2) → next cycle `speaker`=0, `busy`=0, IDLE. Keep `playsound` high through reset release → one CRASH playback of 420 cycles.
- Trigger ID 2 on the final cycle of a running UI_PRESS → no IDLE cycle. CRASH starts at index 0 with HP 255.
